// File: rtl/bin_histogram_sequencer_pkg.sv
// Shared types and sizing for the photon-bin histogram sequencer.
// Holds the sequencer state encoding and the default counter/window widths.
package bin_histogram_sequencer_pkg;

    localparam int NUM_BINS      = 8;
    localparam int CNT_W_DEFAULT = 16;
    localparam int WIN_W_DEFAULT = 24;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CLEAR   = 2'd1,
        ACQUIRE = 2'd2,
        READOUT = 2'd3
    } state_t;

endpackage

// File: rtl/bin_sat_counter.sv
// One histogram bin: a saturating photon counter with a sticky saturation flag.
// Both the count and the flag return to zero on clear.
module bin_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clkin,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    // NOTE: state registers use non-blocking assignments so that every flop samples pre-edge values.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            sat   <= 1'b0;
        end else if (clear) begin
            count <= '0;
            sat   <= 1'b0;
        end else if (enable && inc) begin
            // Saturate at all-ones and remember that a photon was lost.
            if (&count) sat   <= 1'b1;
            else        count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/bin_histogram_sequencer.sv
// Acquisition sequencer: clears eight bin counters, accumulates photon flags
// over a programmed window, then streams the counts out over a valid/ready port.
module bin_histogram_sequencer
    import bin_histogram_sequencer_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT,
    parameter int WIN_W = WIN_W_DEFAULT
) (
    input  logic             clkin,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIN_W-1:0] window_len,
    input  logic [7:0]       bin_data,
    input  logic             rd_ready,
    output logic             rd_valid,
    output logic [2:0]       rd_bin,
    output logic [CNT_W-1:0] rd_count,
    output logic             busy,
    output logic             overflow,
    output logic             done
);

    localparam logic [2:0] LAST_BIN = 3'(NUM_BINS - 1);

    state_t             state, state_nxt;
    logic [1:0]         rst_sync;
    logic               rst_sync_n;
    logic [WIN_W-1:0]   win_cnt;
    logic [CNT_W-1:0]   cnt [NUM_BINS];
    logic [NUM_BINS-1:0] sat;
    logic               xfer;
    logic [CNT_W-1:0]   first_count;

    // NOTE: reset asserts asynchronously but releases only after two clkin edges, avoiding a metastable release.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_sync_n = rst_sync[1];

    for (genvar i = 0; i < NUM_BINS; i++) begin : g_bin
        bin_sat_counter #(.CNT_W(CNT_W)) u_cnt (
            .clkin  (clkin),
            .rst_n  (rst_sync_n),
            .clear  (state == CLEAR),
            .enable (state == ACQUIRE),
            .inc    (bin_data[i]),
            .count  (cnt[i]),
            .sat    (sat[i])
        );
    end

    always_ff @(posedge clkin or negedge rst_sync_n) begin
        if (!rst_sync_n) state <= IDLE;
        else             state <= state_nxt;
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        xfer      = (state == READOUT) && rd_valid && rd_ready;
        // Bin 0 is presented on the same edge as the final sample lands, so fold that sample in here.
        first_count = (&cnt[0]) ? cnt[0] : cnt[0] + CNT_W'(bin_data[0]);
        if (state != IDLE && abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_nxt = CLEAR;
                CLEAR:   state_nxt = (win_cnt == '0) ? READOUT : ACQUIRE;
                ACQUIRE: if (win_cnt == WIN_W'(1)) state_nxt = READOUT;
                READOUT: if (xfer && rd_bin == LAST_BIN) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clkin or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            win_cnt  <= '0;
            rd_bin   <= '0;
            rd_count <= '0;
            rd_valid <= 1'b0;
            busy     <= 1'b0;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            busy     <= (state_nxt != IDLE);
            rd_valid <= (state_nxt == READOUT);
            done     <= xfer && (rd_bin == LAST_BIN) && !abort;
            overflow <= (state == CLEAR) ? 1'b0 : |sat;

            if (state == IDLE && start)  win_cnt <= window_len;
            else if (state == ACQUIRE)   win_cnt <= win_cnt - WIN_W'(1);

            // Counts are frozen in READOUT, so the next word can be fetched on the transfer edge.
            if (state_nxt != READOUT) begin
                rd_bin   <= '0;
                rd_count <= '0;
            end else if (state != READOUT) begin
                rd_bin   <= '0;
                rd_count <= (state == ACQUIRE) ? first_count : '0;
            end else if (xfer) begin
                rd_bin   <= rd_bin + 3'd1;
                rd_count <= cnt[rd_bin + 3'd1];
            end
        end
    end

endmodule

// File: tb/tb_bin_histogram_sequencer.sv
// Directed bench for bin_histogram_sequencer: a 16-bit and a 4-bit counter
// instance run the same stimulus and are checked against hand-computed counts.
module tb_bin_histogram_sequencer;

    logic        clkin;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [23:0] window_len;
    logic [7:0]  bin_data;
    logic        rd_ready;

    logic        v16, busy16, ov16, done16;
    logic [2:0]  b16;
    logic [15:0] c16;
    logic        v4, busy4, ov4, done4;
    logic [2:0]  b4;
    logic [3:0]  c4;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] exp16 [8];
    logic [3:0]  exp4  [8];
    logic        rdy_pat [4];

    bin_histogram_sequencer dut16 (
        .clkin(clkin), .rst_n(rst_n), .start(start), .abort(abort),
        .window_len(window_len), .bin_data(bin_data), .rd_ready(rd_ready),
        .rd_valid(v16), .rd_bin(b16), .rd_count(c16),
        .busy(busy16), .overflow(ov16), .done(done16)
    );

    bin_histogram_sequencer #(.CNT_W(4)) dut4 (
        .clkin(clkin), .rst_n(rst_n), .start(start), .abort(abort),
        .window_len(window_len), .bin_data(bin_data), .rd_ready(rd_ready),
        .rd_valid(v4), .rd_bin(b4), .rd_count(c4),
        .busy(busy4), .overflow(ov4), .done(done4)
    );

    initial clkin = 1'b0;
    always #5 clkin = ~clkin;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clkin);
        #1;
    endtask

    // Start an acquisition and wait for the first readout word, checking the latency.
    task automatic run_acq(input logic [23:0] len, input logic [7:0] data);
        int lat;
        window_len = len;
        bin_data   = data;
        start      = 1'b1;
        tick();
        start = 1'b0;
        lat   = 1;
        while (!v16 && lat < 64) begin
            tick();
            lat++;
        end
        check("latency", lat, (len == 24'd0) ? 32'd2 : 32'(len) + 32'd2);
    endtask

    // Drain eight words with the rd_ready pattern; start is held high to prove it is ignored.
    task automatic readout(input logic ov16_e, input logic ov4_e);
        int idx;
        int cyc;
        idx = 0;
        cyc = 0;
        check("ovf16_rd", ov16, ov16_e);
        check("ovf4_rd", ov4, ov4_e);
        while (idx < 8 && cyc < 64) begin
            rd_ready   = rdy_pat[cyc % 4];
            start      = 1'b1;
            window_len = 24'd0;
            check("rd_valid", v16 & v4, 1);
            check("rd_bin16", b16, idx);
            check("rd_bin4", b4, idx);
            check("rd_count16", c16, exp16[idx]);
            check("rd_count4", c4, exp4[idx]);
            if (rd_ready) idx++;
            tick();
            cyc++;
        end
        start    = 1'b0;
        rd_ready = 1'b1;
        check("words", idx, 8);
        check("done16", done16, 1);
        check("done4", done4, 1);
        check("valid_off", v16 | v4, 0);
        check("busy_off", busy16 | busy4, 0);
        check("ovf16_end", ov16, ov16_e);
        check("ovf4_end", ov4, ov4_e);
        tick();
        check("done_pulse", done16 | done4, 0);
    endtask

    initial begin
        logic seen;
        rst_n      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        window_len = '0;
        bin_data   = '0;
        rd_ready   = 1'b1;
        rdy_pat    = '{1'b1, 1'b1, 1'b1, 1'b1};

        repeat (3) tick();
        check("rst_busy", busy16 | busy4, 0);
        check("rst_valid", v16 | v4, 0);
        check("rst_done", done16 | done4, 0);
        check("rst_ovf", ov16 | ov4, 0);
        check("rst_bin", b16, 0);
        check("rst_count", c16, 0);
        rst_n = 1'b1;
        repeat (3) tick();
        check("idle_busy", busy16, 0);

        // Single bin, window of 4.
        exp16 = '{16'd4, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        exp4  = '{4'd4, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        run_acq(24'd4, 8'h01);
        readout(1'b0, 1'b0);

        // All bins for 20 samples: 4-bit instance saturates at 15.
        exp16 = '{16'd20, 16'd20, 16'd20, 16'd20, 16'd20, 16'd20, 16'd20, 16'd20};
        exp4  = '{4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15};
        run_acq(24'd20, 8'hFF);
        readout(1'b0, 1'b1);

        // Zero-length window goes straight to readout and clears the old overflow.
        exp16 = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        exp4  = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        run_acq(24'd0, 8'hFF);
        readout(1'b0, 1'b0);

        // Sparse pattern with back-pressure 1,0,0,1.
        exp16   = '{16'd3, 16'd0, 16'd3, 16'd0, 16'd0, 16'd3, 16'd0, 16'd3};
        exp4    = '{4'd3, 4'd0, 4'd3, 4'd0, 4'd0, 4'd3, 4'd0, 4'd3};
        rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        run_acq(24'd3, 8'hA5);
        readout(1'b0, 1'b0);
        rdy_pat = '{1'b1, 1'b1, 1'b1, 1'b1};

        // Abort in the third ACQUIRE cycle of a 10-cycle window.
        window_len = 24'd10;
        bin_data   = 8'h01;
        start      = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        check("acq_busy", busy16, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", busy16 | busy4, 0);
        check("abort_valid", v16 | v4, 0);
        check("abort_done", done16 | done4, 0);
        seen = 1'b0;
        repeat (15) begin
            tick();
            seen = seen | v16 | done16 | busy16;
        end
        check("abort_quiet", seen, 0);

        // Abort wins over a transfer in READOUT.
        run_acq(24'd0, 8'h00);
        rd_ready = 1'b1;
        abort    = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_rd_valid", v16, 0);
        check("abort_rd_done", done16, 0);
        check("abort_rd_busy", busy16, 0);
        tick();
        check("abort_rd_nodone", done16, 0);

        // Reset pulse during READOUT at bin 5.
        run_acq(24'd2, 8'hFF);
        rd_ready = 1'b1;
        for (int i = 0; i < 16 && b16 != 3'd5; i++) tick();
        check("at_bin5", b16, 5);
        check("at_bin5_count", c16, 2);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", v16 | v4, 0);
        check("arst_bin", b16, 0);
        check("arst_count", c16, 0);
        check("arst_busy", busy16 | busy4, 0);
        check("arst_ovf", ov16 | ov4, 0);
        check("arst_done", done16 | done4, 0);
        @(posedge clkin);
        #1 rst_n = 1'b1;
        repeat (3) tick();
        check("post_rst_busy", busy16, 0);
        check("post_rst_valid", v16, 0);

        exp16 = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd1};
        exp4  = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1};
        run_acq(24'd1, 8'h80);
        readout(1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bin_histogram_sequencer.md
BIN_HISTOGRAM_SEQUENCER -- requirements
Module: bin_histogram_sequencer

Interface
REQ-001 Parameter CNT_W, default 16, width of each per-bin photon count.
REQ-002 Parameter WIN_W, default 24, width of the acquisition-window length.
REQ-003 clkin  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  single-cycle request to begin one acquisition.
REQ-006 abort  input  1  cancels any acquisition or readout in progress.
REQ-007 window_len  input  WIN_W  acquisition length in clkin cycles, sampled on an accepted start.
REQ-008 bin_data  input  8  registered eighth-of-cycle photon flags from the binning stage, one bit per bin.
REQ-009 rd_ready  input  1  downstream ready for readout words.
REQ-010 rd_valid  output  1  readout word valid.
REQ-011 rd_bin  output  3  bin index of the current readout word.
REQ-012 rd_count  output  CNT_W  accumulated count for rd_bin.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 overflow  output  1  sticky flag: a bin counter saturated during the current or last acquisition.
REQ-015 done  output  1  one-cycle pulse after the last readout word transfers.

Function
REQ-016 The FSM SHALL have the states IDLE, CLEAR, ACQUIRE and READOUT.
REQ-017 In IDLE, start=1 SHALL move to CLEAR; start in any other state SHALL be ignored.
REQ-018 CLEAR SHALL last one cycle, zero all 8 counters, clear overflow, and load the window counter with window_len.
REQ-019 From CLEAR, the FSM SHALL enter ACQUIRE if the loaded length is nonzero, or READOUT directly (all counts zero) if the length is zero.
REQ-020 ACQUIRE SHALL sample bin_data on exactly window_len consecutive cycles, the first being the cycle after CLEAR.
REQ-021 On each sample, count[i] SHALL increment by bin_data[i] (0 or 1) independently for all 8 bins.
REQ-022 A counter at all-ones SHALL hold its value on a further increment, and that event SHALL set overflow.
REQ-023 The FSM SHALL leave ACQUIRE for READOUT after the window_len-th sample; counters SHALL then be frozen.
REQ-024 In READOUT, rd_valid SHALL be 1, starting with rd_bin=0 and rd_count=count[0].
REQ-025 A transfer SHALL occur when rd_valid and rd_ready are both 1; rd_bin then increments by 1.
REQ-026 While rd_valid=1 and rd_ready=0, rd_bin and rd_count SHALL remain stable.
REQ-027 The transfer of bin 7 SHALL return the FSM to IDLE, drop rd_valid, and pulse done for one cycle.
REQ-028 abort=1 in any non-IDLE state SHALL force IDLE on the next edge, with no done pulse.
REQ-029 abort SHALL take priority over a transfer and over state transitions in the same cycle.
REQ-030 After an abort, counter and overflow contents are don't-care until the next CLEAR.
REQ-031 Outputs SHALL be registered; rd_count SHALL have one cycle of latency from a bin index change.

Reset
REQ-032 rst_n=0 SHALL asynchronously force IDLE, with all counters, window counter, rd_bin, rd_count, rd_valid, busy, overflow and done at 0.
REQ-033 Reset asserted mid-acquisition or mid-readout SHALL discard all progress.
REQ-034 Reset release SHALL be synchronised to clkin before it affects the FSM.

Structure
REQ-035 A shared package SHALL hold the state enum, NUM_BINS=8 and the default CNT_W/WIN_W values.
REQ-036 Each bin SHALL use one sub-module, bin_sat_counter (clear, enable, inc, saturating count, sat flag), instantiated 8 times.

Verification
REQ-037 window_len=4, bin_data=8'h01 constant, rd_ready=1 -> counts {4,0,0,0,0,0,0,0}, 8 words, done 1 cycle after bin 7.
REQ-038 CNT_W=4, window_len=20, bin_data=8'hFF -> all counts 15, overflow=1 during and after readout.
REQ-039 window_len=0 -> CLEAR then READOUT, 8 zero words, overflow=0.
REQ-040 rd_ready toggling 1,0,0,1 during readout -> rd_bin/rd_count stable while stalled, no word duplicated or skipped.
REQ-041 abort in ACQUIRE cycle 3 of 10 -> IDLE next cycle, busy=0, no done; start while busy ignored.
REQ-042 rst_n low for 1 cycle during READOUT at bin 5 -> all outputs 0 immediately, IDLE after release.
